// File: rtl/line_prefetch.sv
// SDRAM line prefetcher: fetches one display line per line_start and assembles each byte lane into pixels.
// Optional macro LINE_PREFETCH_BYTE_SWAP_EN puts the first received byte in the MSB of each lane slice.
module line_prefetch #(
  parameter int LINE_PIXELS     = 720,
  parameter int LINES           = 720,
  parameter int CHANNELS        = 2,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int ADDR_WIDTH      = 25
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    line_start,
  input  logic [9:0]                              line_y,
  output logic [ADDR_WIDTH-1:0]                   sd_addr,
  output logic                                    sd_rd_req,
  output logic                                    sd_end_burst,
  input  logic                                    sd_data_available,
  input  logic [8*CHANNELS-1:0]                   sd_q,
  output logic                                    pix_valid,
  output logic [CHANNELS*8*BYTES_PER_PIXEL-1:0]   pix_data,
  output logic                                    busy,
  output logic                                    line_done
);

  localparam int W     = LINE_PIXELS * BYTES_PER_PIXEL;
  localparam int PIX_W = 8 * BYTES_PER_PIXEL;
  localparam int BI_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

  localparam logic [15:0]           W_CNT   = 16'(W);
  localparam logic [15:0]           W_END   = 16'(W - 2);
  localparam logic [BI_W-1:0]       BI_LAST = BI_W'(BYTES_PER_PIXEL - 1);
  localparam logic [ADDR_WIDTH-1:0] W_ADDR  = ADDR_WIDTH'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_BURST,
    S_DONE
  } state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic [9:0]                        r_line_y;
  logic [ADDR_WIDTH-1:0]             r_base;
  logic [15:0]                       r_count;
  logic [BI_W-1:0]                   r_byte_idx;
  logic                              r_dav_q;
  logic [CHANNELS-1:0][PIX_W-1:0]    r_asm;
  logic [CHANNELS-1:0][PIX_W-1:0]    r_pix_data;
  logic                              r_pix_valid;
  logic                              r_end_burst;

  logic [9:0]                        w_y_eff;
  logic [ADDR_WIDTH-1:0]             w_base;
  logic                              w_capture;
  logic                              w_fall;
  logic                              w_wrap;
  logic [CHANNELS-1:0][PIX_W-1:0]    w_asm_next;

  // Out-of-range line indices fall back to line 0.
  assign w_y_eff   = (32'(r_line_y) >= LINES) ? 10'd0 : r_line_y;
  assign w_base    = ADDR_WIDTH'(w_y_eff) * W_ADDR;

  // Words are only accepted in BURST; an abort on the same cycle drops the word.
  assign w_capture = (r_state == S_BURST) && sd_data_available && (r_count < W_CNT) && !line_start;
  assign w_fall    = (r_state == S_BURST) && r_dav_q && !sd_data_available;
  assign w_wrap    = (r_byte_idx == BI_LAST);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef LINE_PREFETCH_BYTE_SWAP_EN
      w_asm_next[c] = (r_asm[c] << 8) | PIX_W'(sd_q[8*c +: 8]);
`else
      w_asm_next[c] = (r_asm[c] >> 8) | (PIX_W'(sd_q[8*c +: 8]) << (PIX_W - 8));
`endif
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_IDLE;
      S_SETUP: w_state_next = S_REQ;
      S_REQ:   w_state_next = S_BURST;
      S_BURST: begin
        if (w_fall) w_state_next = (r_count < W_CNT) ? S_REQ : S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (line_start) w_state_next = S_SETUP;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (reset) begin
      r_state     <= S_IDLE;
      r_line_y    <= '0;
      r_base      <= '0;
      r_count     <= '0;
      r_byte_idx  <= '0;
      r_dav_q     <= 1'b0;
      r_asm       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_end_burst <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dav_q     <= sd_data_available;
      r_pix_valid <= 1'b0;
      r_end_burst <= 1'b0;
      if (line_start) begin
        r_line_y   <= line_y;
        r_count    <= '0;
        r_byte_idx <= '0;
        r_asm      <= '0;
      end else begin
        if (r_state == S_SETUP) r_base <= w_base;
        if (w_capture) begin
          r_count     <= r_count + 16'd1;
          r_asm       <= w_asm_next;
          // Ask the controller to stop once the last two words are in flight.
          r_end_burst <= (r_count >= W_END);
          if (w_wrap) begin
            r_byte_idx  <= '0;
            r_pix_valid <= 1'b1;
            r_pix_data  <= w_asm_next;
          end else begin
            r_byte_idx  <= r_byte_idx + BI_W'(1);
          end
        end
      end
    end
  end

  assign sd_addr      = r_base + ADDR_WIDTH'(r_count);
  assign sd_rd_req    = (r_state == S_REQ);
  assign sd_end_burst = r_end_burst;
  assign pix_valid    = r_pix_valid;
  assign pix_data     = r_pix_data;
  assign busy         = (r_state == S_SETUP) || (r_state == S_REQ) || (r_state == S_BURST);
  assign line_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_line_prefetch.sv
// Self-checking bench for line_prefetch: vector table, hand-written corner cases and randomized lines
// checked against a word-list pixel model. Honours LINE_PREFETCH_BYTE_SWAP_EN when defined.
module tb_line_prefetch;

  localparam int LP  = 4;
  localparam int LN  = 8;
  localparam int CH  = 2;
  localparam int BPP = 3;
  localparam int AW  = 25;
  localparam int W   = LP * BPP;
  localparam int PXW = 8 * BPP;
  localparam int PW  = CH * PXW;

  logic          clk;
  logic          reset;
  logic          line_start;
  logic [9:0]    line_y;
  logic [AW-1:0] sd_addr;
  logic          sd_rd_req;
  logic          sd_end_burst;
  logic          sd_data_available;
  logic [8*CH-1:0] sd_q;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          busy;
  logic          line_done;

  line_prefetch #(
    .LINE_PIXELS(LP), .LINES(LN), .CHANNELS(CH), .BYTES_PER_PIXEL(BPP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .sd_addr(sd_addr), .sd_rd_req(sd_rd_req), .sd_end_burst(sd_end_burst),
    .sd_data_available(sd_data_available), .sd_q(sd_q),
    .pix_valid(pix_valid), .pix_data(pix_data), .busy(busy), .line_done(line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_eb    = 0;
  logic [PW-1:0] pix_q[$];

  // Event recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid)    pix_q.push_back(pix_data);
      if (line_done)    n_done++;
      if (sd_end_burst) n_eb++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]    y;
    int            split;
    int            extra;
    logic [AW-1:0] exp_base;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sd_data_available = 1'b0;
    repeat (n) step();
  endtask

  task automatic feed(input logic [15:0] w);
    sd_data_available = 1'b1;
    sd_q = w;
    step();
  endtask

  function automatic logic [15:0] pat_word(input int k);
    return {8'(2 * k + 1), 8'(2 * k)};
  endfunction

  // Pixel p lane c is built from bytes of words 3p..3p+2 of that lane.
  function automatic logic [PW-1:0] model_pix(input logic [15:0] words[$], input int p);
    logic [PW-1:0] px;
    px = '0;
    for (int c = 0; c < CH; c++) begin
      for (int b = 0; b < BPP; b++) begin
        logic [15:0] w;
        w = words[p * BPP + b];
`ifdef LINE_PREFETCH_BYTE_SWAP_EN
        px[c * PXW + 8 * (BPP - 1 - b) +: 8] = w[8 * c +: 8];
`else
        px[c * PXW + 8 * b +: 8] = w[8 * c +: 8];
`endif
      end
    end
    return px;
  endfunction

  function automatic logic [AW-1:0] model_base(input logic [9:0] y);
    return (int'(y) >= LN) ? '0 : AW'(int'(y) * W);
  endfunction

  task automatic wait_req(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sd_rd_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, " req_seen"}, 64'(found), 64'd1);
  endtask

  // Pulses line_start (caller controls sd_data_available during the pulse), checks SETUP then REQ timing.
  task automatic start_line(input logic [9:0] y, input logic [AW-1:0] exp_base, input string tag);
    line_start = 1'b1;
    line_y = y;
    step();
    line_start = 1'b0;
    sd_data_available = 1'b0;
    check({tag, " setup_busy"}, 64'(busy), 64'd1);
    check({tag, " setup_noreq"}, 64'(sd_rd_req), 64'd0);
    step();
    check({tag, " req"}, 64'(sd_rd_req), 64'd1);
    check({tag, " req_addr"}, 64'(sd_addr), 64'(exp_base));
  endtask

  // Supplies a line's words from the REQ cycle onward, optionally split into two bursts.
  task automatic body(input logic [15:0] words[$], input logic [AW-1:0] base, input int split,
                      input int lat, input string tag);
    int done0;
    int eb0;
    bit found;
    bool_pv: begin end
    done0 = n_done;
    eb0 = n_eb;
    idle(lat);
    for (int j = 0; j < words.size(); j++) begin
      bit wrap;
      if (split > 0 && j == split) begin
        sd_data_available = 1'b0;
        step();
        wait_req(tag, found);
        if (found) check({tag, " rereq_addr"}, 64'(sd_addr), 64'(AW'(base + AW'(j))));
        idle(lat);
      end
      feed(words[j]);
      wrap = (j < W) && (j % BPP == BPP - 1);
      check($sformatf("%s pv%0d", tag, j), 64'(pix_valid), 64'(wrap));
      if (wrap) check($sformatf("%s pix%0d", tag, j / BPP), 64'(pix_data), 64'(model_pix(words, j / BPP)));
      check($sformatf("%s eb%0d", tag, j), 64'(sd_end_burst), 64'((j >= W - 2) && (j < W)));
    end
    sd_data_available = 1'b0;
    step();
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (line_done) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, " line_done_seen"}, 64'(found), 64'd1);
    step();
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " done_count"}, 64'(n_done - done0), 64'd1);
    check({tag, " eb_count"}, 64'(n_eb - eb0), 64'd2);
    check({tag, " pix_count"}, 64'(pix_q.size()), 64'(LP));
    for (int p = 0; p < LP && p < pix_q.size(); p++)
      check($sformatf("%s q_pix%0d", tag, p), 64'(pix_q[p]), 64'(model_pix(words, p)));
  endtask

  task automatic run_line(input logic [9:0] y, input logic [AW-1:0] exp_base, input int split,
                          input int lat, input int extra, input bit use_pat, input string tag);
    logic [15:0] words[$];
    for (int k = 0; k < W + extra; k++)
      words.push_back(use_pat ? pat_word(k) : 16'($urandom));
    pix_q.delete();
    sd_data_available = 1'b0;
    start_line(y, exp_base, tag);
    body(words, exp_base, split, lat, tag);
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] nw[$];
    logic [PW-1:0] first_pix;

    vecs[0] = '{y: 10'd2,    split: 0,  extra: 0, exp_base: 25'd24};
    vecs[1] = '{y: 10'd2,    split: 5,  extra: 0, exp_base: 25'd24};
    vecs[2] = '{y: 10'd8,    split: 0,  extra: 0, exp_base: 25'd0};
    vecs[3] = '{y: 10'd7,    split: 11, extra: 0, exp_base: 25'd84};
    vecs[4] = '{y: 10'd0,    split: 0,  extra: 2, exp_base: 25'd0};
    vecs[5] = '{y: 10'd1023, split: 3,  extra: 1, exp_base: 25'd0};
`ifdef LINE_PREFETCH_BYTE_SWAP_EN
    first_pix = 48'h010305_000204;
`else
    first_pix = 48'h050301_040200;
`endif

    reset = 1'b1;
    line_start = 1'b0;
    line_y = '0;
    sd_data_available = 1'b0;
    sd_q = '0;
    repeat (3) step();
    check("rst sd_rd_req", 64'(sd_rd_req), 64'd0);
    check("rst sd_end_burst", 64'(sd_end_burst), 64'd0);
    check("rst pix_valid", 64'(pix_valid), 64'd0);
    check("rst line_done", 64'(line_done), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst pix_data", 64'(pix_data), 64'd0);
    check("rst sd_addr", 64'(sd_addr), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_line(vecs[i].y, vecs[i].exp_base, vecs[i].split, 1 + (i % 3), vecs[i].extra, 1'b1,
               $sformatf("vec%0d", i));
      if (i == 0) check("first_pixel", 64'((pix_q.size() > 0) ? pix_q[0] : '0), 64'(first_pix));
    end

    // Abort mid-burst; the word presented with the new line_start is dropped.
    pix_q.delete();
    start_line(10'd2, 25'd24, "abort_old");
    idle(1);
    for (int k = 0; k < 7; k++) feed(pat_word(k));
    sd_q = pat_word(7);
    sd_data_available = 1'b1;
    start_line(10'd3, 25'd36, "abort");
    check("abort old_pix_count", 64'(pix_q.size()), 64'd2);
    pix_q.delete();
    for (int k = 0; k < W; k++) nw.push_back(16'($urandom));
    body(nw, 25'd36, 0, 2, "abort_new");

    // Reset mid-burst returns everything to idle in one cycle.
    pix_q.delete();
    start_line(10'd5, 25'd60, "rst_mid");
    idle(1);
    for (int k = 0; k < 5; k++) feed(pat_word(k));
    reset = 1'b1;
    sd_data_available = 1'b1;
    step();
    check("rst_mid sd_rd_req", 64'(sd_rd_req), 64'd0);
    check("rst_mid sd_end_burst", 64'(sd_end_burst), 64'd0);
    check("rst_mid pix_valid", 64'(pix_valid), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid pix_data", 64'(pix_data), 64'd0);
    check("rst_mid sd_addr", 64'(sd_addr), 64'd0);
    reset = 1'b0;
    pix_q.delete();
    for (int k = 0; k < 4; k++) feed(pat_word(k));
    idle(3);
    check("rst_mid idle_busy", 64'(busy), 64'd0);
    check("rst_mid idle_req", 64'(sd_rd_req), 64'd0);
    check("rst_mid no_pix", 64'(pix_q.size()), 64'd0);
    run_line(10'd4, 25'd48, 0, 1, 0, 1'b1, "rst_recover");

    // Randomized lines against the model.
    for (int r = 0; r < 20; r++) begin
      logic [9:0] y;
      int split;
      y = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(LN, 1023)) : 10'($urandom_range(0, LN - 1));
      split = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : 0;
      run_line(y, model_base(y), split, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0,
               $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
